// File: rtl/serial_sub_pkg.sv
// +----------------------------------------------------------------------------+
// | serial_sub_pkg                                                             |
// | Shared FSM state encoding and counter sizing for serial_subtractor.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must hold the value WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_sub_bit.sv
// +----------------------------------------------------------------------------+
// | full_sub_bit                                                               |
// | Combinational one-bit full subtractor: d = a - b - bin, bout = borrow.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | serial_subtractor                                                          |
// | Bit-serial a - b, LSB first, one full-subtractor cell, valid/ready I/O.    |
// | Optional signed-overflow output enabled by SERIAL_SUB_OVERFLOW_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_live;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   w_diff_nxt;
    logic               r_bor;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_d;
    logic               w_bout;
    logic               w_load;
    logic               w_last;

    full_sub_bit u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    // r_live keeps in_ready low while reset is asserted even though the FSM sits in IDLE.
    assign in_ready  = r_live && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_load    = in_valid && in_ready;
    assign w_last    = (r_cnt == c_last);
    assign diff      = r_diff;
    assign borrow    = r_bor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_load)    w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // New result bit enters at the MSB so the LSB-first stream lands in place.
    always_comb begin
        w_diff_nxt            = r_diff >> 1;
        w_diff_nxt[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_a    <= a;
            r_b    <= b;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_diff <= w_diff_nxt;
            r_bor  <= w_bout;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    assign overflow = r_ovf;

    // The MSB result bit is produced on the last shift; overflow is decided then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_ovf   <= 1'b0;
        end else if ((r_state == ST_SHIFT) && w_last) begin
            r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | tb_serial_subtractor                                                       |
// | Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1;
    logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf8, ovf1;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc8   = 0;
    int   n_pop8   = 0;
    exp_t q8[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow  (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow  (ovf1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        e.ovf    = (av[7] ^ bv[7]) & (av[7] ^ e.diff[7]);
        return e;
    endfunction

    function automatic exp_t model1(input logic av, input logic bv);
        exp_t e;
        logic d;
        d        = av ^ bv;
        e.diff   = {7'd0, d};
        e.borrow = (av == 1'b0) && (bv == 1'b1);
        e.ovf    = (av ^ bv) & (av ^ d);
        return e;
    endfunction

    // Scoreboard: push at the accepting cycle, pop at the output handshake cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid8 && in_ready8) begin
                q8.push_back(model8(a8, b8));
                n_acc8++;
            end
            if (out_valid8 && out_ready8) begin
                n_pop8++;
                if (q8.size() == 0) chk("sb8_unexpected", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    chk("sb8_diff", diff8, e.diff);
                    chk("sb8_borrow", borrow8, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    chk("sb8_ovf", ovf8, e.ovf);
`endif
                end
            end
            if (in_valid1 && in_ready1) q1.push_back(model1(a1[0], b1[0]));
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) chk("sb1_unexpected", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("sb1_diff", diff1, e.diff[0]);
                    chk("sb1_borrow", borrow1, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    chk("sb1_ovf", ovf1, e.ovf);
`endif
                end
            end
        end
    end

    always @(negedge rst_n) begin
        q8.delete();
        q1.delete();
    end

    task automatic send8(input logic [7:0] av, input logic [7:0] bv);
        bit ok = 1'b0;
        a8 = av; b8 = bv; in_valid8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready8) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept8_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_valid8(output int edges);
        edges = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            edges++;
            if (out_valid8) return;
        end
        chk("valid8_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int         lat;
        int         base_acc, base_pop;
        logic [7:0] snap_d;
        logic       snap_b;

        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
        #22;
        chk("rst_in_ready", in_ready8, 0);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_diff", diff8, 8'h00);
        chk("rst_borrow", borrow8, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready8, 1);

        send8(8'h5A, 8'h3C);
        wait_valid8(lat);
        chk("latency_edges", lat, 9);
        @(posedge clk); #1;

        send8(8'h00, 8'h01); wait_valid8(lat); @(posedge clk); #1;
        send8(8'h80, 8'h01); wait_valid8(lat); @(posedge clk); #1;
        send8(8'h7F, 8'hFF); wait_valid8(lat); @(posedge clk); #1;

        // Backpressure: DONE held five cycles, then released.
        out_ready8 = 1'b0;
        send8(8'h12, 8'h34);
        wait_valid8(lat);
        snap_d = diff8; snap_b = borrow8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid8, 1);
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_diff_stable", diff8, snap_d);
            chk("bp_borrow_stable", borrow8, snap_b);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(negedge clk);
        chk("hs_cycle_in_ready", in_ready8, 0);
        @(posedge clk); #1;
        chk("after_hs_in_ready", in_ready8, 1);
        chk("after_hs_out_valid", out_valid8, 0);

        // in_valid held high with operands changing every cycle.
        base_acc = n_acc8; base_pop = n_pop8;
        a8 = 8'h11; b8 = 8'h22; in_valid8 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (n_acc8 - base_acc >= 2) break;
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        in_valid8 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("two_results", n_pop8 - base_pop, 2);

        // Asynchronous reset in the middle of a SHIFT.
        send8(8'hA5, 8'h0F);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid8, 0);
        chk("mid_rst_in_ready", in_ready8, 0);
        chk("mid_rst_diff", diff8, 8'h00);
        chk("mid_rst_borrow", borrow8, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("mid_rst_ovf", ovf8, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_idle_ready", in_ready8, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", out_valid8, 0);
        end

        // WIDTH=1 sweep over all operand pairs.
        for (int p = 0; p < 4; p++) begin
            bit ok = 1'b0;
            a1 = 1'(p >> 1); b1 = 1'(p); in_valid1 = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (in_ready1) begin ok = 1'b1; break; end
            end
            if (!ok) chk("accept1_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid1) begin ok = 1'b1; break; end
            end
            if (!ok) chk("valid1_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb8_drained", q8.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
